// File: rtl/mux_scan_n.sv
// N-channel registered mux with manual select and auto-scan modes.
// Optional channel masking is compiled in with `define MUX_SCAN_MASK_EN.
module mux_scan_n #(
  parameter int WIDTH = 1,
  parameter int NCH   = 4,
  parameter int SELW  = 2,
  parameter int DWELL = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] din,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic                 en,
`ifdef MUX_SCAN_MASK_EN
  input  logic [NCH-1:0]       ch_mask,
`endif
  output logic [WIDTH-1:0]     dout,
  output logic [SELW-1:0]      ch,
  output logic                 valid,
  output logic                 wrap,
  output logic                 err
);

  localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [WIDTH-1:0] dout_q, dout_d;
  logic [SELW-1:0]  ch_q, ch_d;
  logic [SELW-1:0]  ptr_q, ptr_d;
  logic [DCW-1:0]   dcnt_q, dcnt_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  logic [NCH-1:0]   mask_w;
  logic             sel_ok, ptr_ok, any_en, found_after, dwell_done;
  logic [WIDTH-1:0] sel_data, ptr_data;
  logic [SELW-1:0]  nxt_after, nxt_any, nxt_ptr;

`ifdef MUX_SCAN_MASK_EN
  assign mask_w = ch_mask;
`else
  assign mask_w = '1;
`endif

  // Static slices only: an out-of-range sel simply matches no channel.
  always_comb begin
    sel_ok   = 1'b0;
    sel_data = '0;
    ptr_ok   = 1'b0;
    ptr_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (int'(sel) == k) begin
        sel_ok   = mask_w[k];
        sel_data = din[k*WIDTH +: WIDTH];
      end
      if (int'(ptr_q) == k) begin
        ptr_ok   = mask_w[k];
        ptr_data = din[k*WIDTH +: WIDTH];
      end
    end
  end

  // Next enabled channel: lowest enabled index above ptr, else lowest overall.
  // Falling back to the lowest overall is exactly the next<=ptr wrap case.
  always_comb begin
    found_after = 1'b0;
    nxt_after   = '0;
    nxt_any     = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (mask_w[k]) begin
        nxt_any = SELW'(k);
        if (k > int'(ptr_q)) begin
          found_after = 1'b1;
          nxt_after   = SELW'(k);
        end
      end
    end
    any_en     = |mask_w;
    nxt_ptr    = found_after ? nxt_after : nxt_any;
    dwell_done = (int'(dcnt_q) == DWELL - 1);
  end

  always_comb begin
    dout_d  = dout_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    dcnt_d  = dcnt_q;
    err_d   = err_q;
    valid_d = 1'b0;
    wrap_d  = 1'b0;
    if (!mode) begin
      ptr_d  = '0;
      dcnt_d = '0;
      if (en) begin
        if (sel_ok) begin
          dout_d  = sel_data;
          ch_d    = sel;
          valid_d = 1'b1;
          err_d   = 1'b0;
        end else begin
          err_d = 1'b1;
        end
      end
    end else if (en) begin
      err_d = 1'b0;
      if (!any_en) begin
        ptr_d = ptr_q;
      end else if (!ptr_ok) begin
        ptr_d  = nxt_ptr;
        dcnt_d = '0;
      end else begin
        dout_d  = ptr_data;
        ch_d    = ptr_q;
        valid_d = 1'b1;
        if (dwell_done) begin
          dcnt_d = '0;
          ptr_d  = nxt_ptr;
          wrap_d = !found_after;
        end else begin
          dcnt_d = dcnt_q + DCW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q  <= '0;
      ch_q    <= '0;
      ptr_q   <= '0;
      dcnt_q  <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      dout_q  <= dout_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
      dcnt_q  <= dcnt_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign dout  = dout_q;
  assign ch    = ch_q;
  assign valid = valid_q;
  assign wrap  = wrap_q;
  assign err   = err_q;

endmodule
